// File: rtl/dma_controller.sv
// ---------------------------------------------------------------------------
// dma_controller
//
// Single-channel memory-to-memory copy engine. Accepts a (src, dst, len)
// command, requests the CPU bus with BR, and once BG is granted copies len
// words in ascending order. Each word takes three cycles: RD1 (address out),
// RD2 (data captured) and WR (data driven back out to the destination).
// The bus is released only at word boundaries.
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   reset      - asynchronous, active-high reset
//   cmd_valid  - transfer command present
//   cmd_ready  - high in IDLE only; command taken on cmd_valid & cmd_ready
//   cmd_src    - source start word address (sampled at acceptance)
//   cmd_dst    - destination start word address (sampled at acceptance)
//   cmd_len    - word count (sampled at acceptance)
//   BR         - bus request to the CPU
//   BG         - bus grant from the CPU
//   d_readM    - memory data-port read strobe
//   d_writeM   - memory data-port write strobe
//   d_address  - memory data-port word address
//   d_data     - bidirectional memory data bus, driven only while writing
//   busy       - high in every state except IDLE
//   done       - one-cycle completion pulse
// ---------------------------------------------------------------------------
module dma_controller #(
    parameter int WORD_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [WORD_SIZE-1:0] cmd_src,
    input  logic [WORD_SIZE-1:0] cmd_dst,
    input  logic [WORD_SIZE-1:0] cmd_len,
    output logic                 BR,
    input  logic                 BG,
    output logic                 d_readM,
    output logic                 d_writeM,
    output logic [WORD_SIZE-1:0] d_address,
    inout  wire  [WORD_SIZE-1:0] d_data,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        RD1  = 3'd2,
        RD2  = 3'd3,
        WR   = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t state_reg, state_next;

    logic [WORD_SIZE-1:0] src_reg;
    logic [WORD_SIZE-1:0] dst_reg;
    logic [WORD_SIZE-1:0] len_reg;
    logic [WORD_SIZE-1:0] index_reg;
    logic [WORD_SIZE-1:0] buffer_reg;

    logic [WORD_SIZE-1:0] index_inc;
    logic                 last_word;
    logic                 drive_data;

    assign index_inc = index_reg + WORD_SIZE'(1);
    // Evaluated in WR, before the index increments at the end of that cycle.
    assign last_word = (index_inc == len_reg);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    state_next = (cmd_len == '0) ? DONE : REQ;
                end
            end
            REQ: begin
                if (BG) begin
                    state_next = RD1;
                end
            end
            // Once a word has started it always runs to completion; BG is
            // only looked at again after the write.
            RD1: state_next = RD2;
            RD2: state_next = WR;
            WR: begin
                if (last_word) begin
                    state_next = DONE;
                end else if (BG) begin
                    state_next = RD1;
                end else begin
                    state_next = REQ;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers: command latch, word index, read buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_reg    <= '0;
            dst_reg    <= '0;
            len_reg    <= '0;
            index_reg  <= '0;
            buffer_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        src_reg   <= cmd_src;
                        dst_reg   <= cmd_dst;
                        len_reg   <= cmd_len;
                        index_reg <= '0;
                    end
                end
                RD2:     buffer_reg <= d_data;
                WR:      index_reg  <= index_inc;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode (state and registers only)
    // ------------------------------------------------------------------
    always_comb begin
        cmd_ready  = 1'b0;
        BR         = 1'b0;
        d_readM    = 1'b0;
        d_writeM   = 1'b0;
        d_address  = '0;
        drive_data = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            REQ: begin
                BR = 1'b1;
            end
            RD1, RD2: begin
                BR        = 1'b1;
                d_readM   = 1'b1;
                d_address = src_reg + index_reg;   // wraps modulo 2^WORD_SIZE
            end
            WR: begin
                BR         = 1'b1;
                d_writeM   = 1'b1;
                d_address  = dst_reg + index_reg;  // wraps modulo 2^WORD_SIZE
                drive_data = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign d_data = drive_data ? buffer_reg : {WORD_SIZE{1'bz}};

endmodule

// File: tb/tb_dma_controller.sv
// ---------------------------------------------------------------------------
// tb_dma_controller
//
// Bench for dma_controller. A 64K-word memory sits on the data port and a
// reference copy of that memory is updated by a simple sequential copy model
// after each transfer. Table-driven transfers (BG held high) check completion
// latency, done pulse width and memory contents; hand-written sequences cover
// bus-grant stalls, reset in the middle of a transfer and commands issued
// while busy.
// ---------------------------------------------------------------------------
module tb_dma_controller;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_src;
    logic [15:0] cmd_dst;
    logic [15:0] cmd_len;
    logic        BR;
    logic        BG;
    logic        d_readM;
    logic        d_writeM;
    logic [15:0] d_address;
    wire  [15:0] d_data;
    logic        busy;
    logic        done;

    dma_controller #(.WORD_SIZE(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_src   (cmd_src),
        .cmd_dst   (cmd_dst),
        .cmd_len   (cmd_len),
        .BR        (BR),
        .BG        (BG),
        .d_readM   (d_readM),
        .d_writeM  (d_writeM),
        .d_address (d_address),
        .d_data    (d_data),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory on the data port and its reference model.
    logic [15:0] mem   [0:65535];
    logic [15:0] model [0:65535];

    assign d_data = d_readM ? mem[d_address] : 16'bz;

    always @(posedge clk) begin
        if (d_writeM) mem[d_address] <= d_data;
    end

    // Event counters, written only here.
    int br_cnt;
    int strobe_cnt;
    int both_cnt;
    int done_cnt;

    initial begin
        br_cnt = 0; strobe_cnt = 0; both_cnt = 0; done_cnt = 0;
    end

    always @(negedge clk) begin
        if (BR) br_cnt++;
        if (d_readM || d_writeM) strobe_cnt++;
        if (d_readM && d_writeM) both_cnt++;
        if (done) done_cnt++;
    end

    int total;
    int bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] pattern(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    // Reference copy: ascending, word by word, so overlaps resolve the same
    // way a sequential copy would.
    task automatic model_copy(input logic [15:0] src, input logic [15:0] dst, input int n);
        logic [15:0] off;
        for (int i = 0; i < n; i++) begin
            off = 16'(i);
            model[16'(dst + off)] = model[16'(src + off)];
        end
    endtask

    task automatic check_mem(input string name);
        int nbad;
        int first;
        nbad = 0;
        first = 0;
        for (int a = 0; a < 65536; a++) begin
            if (mem[a] !== model[a]) begin
                if (nbad == 0) first = a;
                nbad++;
            end
        end
        total++;
        if (nbad != 0) begin
            bad++;
            $display("FAIL %s: %0d words differ, first at %0h got %0h expected %0h",
                     name, nbad, first, mem[first], model[first]);
        end
    endtask

    // Present a command in IDLE; returns just after the acceptance edge.
    task automatic start_cmd(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len);
        @(negedge clk);
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_src   = src;
        cmd_dst   = dst;
        cmd_len   = len;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Count edges after acceptance until done is seen. With poke set, a
    // second command is offered for one cycle while the engine is busy.
    task automatic wait_done(input bit poke, output int cycles);
        cycles = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            if (poke && cycles == 2) begin
                check("cmd_ready_busy", cmd_ready, 0);
                cmd_valid = 1'b1;
                cmd_src   = 16'h3333;
                cmd_dst   = 16'hD001;
                cmd_len   = 16'd1;
            end else begin
                cmd_valid = 1'b0;
            end
            if (cycles > 400) begin
                total++;
                bad++;
                $display("FAIL done_timeout: got no done after %0d cycles", cycles);
                break;
            end
            @(posedge clk);
            cycles++;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic check_after_done();
        @(negedge clk);
        check("done_single_pulse", done, 0);
        check("idle_after_done", {busy, cmd_ready}, 2'b01);
    endtask

    typedef struct {
        logic [15:0] src;
        logic [15:0] dst;
        logic [15:0] len;
        int          exp_cycles;
        bit          poke;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int cycles;
        int br0, st0, dn0, hits, found;

        total = 0;
        bad   = 0;

        //           src       dst       len   cycles  poke
        vecs[0] = '{16'h0001, 16'h0100, 16'd2, 7,      1'b0};  // basic two-word copy
        vecs[1] = '{16'h0010, 16'h0020, 16'd0, 0,      1'b0};  // empty transfer
        vecs[2] = '{16'hFFFF, 16'h0300, 16'd2, 7,      1'b0};  // source wraps
        vecs[3] = '{16'h0400, 16'h01FF, 16'd2, 7,      1'b0};  // destination crosses 0x0200
        vecs[4] = '{16'h0500, 16'h0600, 16'd5, 16,     1'b0};
        vecs[5] = '{16'h0700, 16'h0701, 16'd3, 10,     1'b0};  // overlapping, ascending copy
        vecs[6] = '{16'h0C00, 16'h0D00, 16'd2, 7,      1'b1};  // command while busy

        for (int a = 0; a < 65536; a++) begin
            mem[a]   = pattern(16'(a));
            model[a] = pattern(16'(a));
        end
        mem[1] = 16'h0001; model[1] = 16'h0001;
        mem[2] = 16'hFFFF; model[2] = 16'hFFFF;

        cmd_valid = 1'b0;
        cmd_src   = '0;
        cmd_dst   = '0;
        cmd_len   = '0;
        BG        = 1'b0;
        reset     = 1'b0;

        #3 reset = 1'b1;
        #1;
        check("reset_outputs", {BR, d_readM, d_writeM, busy, done}, 5'b0);
        check("reset_address", d_address, 16'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {cmd_ready, busy}, 2'b10);

        // ---------------- table-driven transfers, BG held high -------------
        BG = 1'b1;
        for (int v = 0; v < 7; v++) begin
            br0 = br_cnt;
            st0 = strobe_cnt;
            dn0 = done_cnt;
            start_cmd(vecs[v].src, vecs[v].dst, vecs[v].len);
            wait_done(vecs[v].poke, cycles);
            check($sformatf("latency_v%0d", v), cycles, vecs[v].exp_cycles);
            check_after_done();
            check($sformatf("done_count_v%0d", v), done_cnt - dn0, 1);
            if (vecs[v].len == 0) begin
                check("len0_no_br", br_cnt - br0, 0);
                check("len0_no_strobe", strobe_cnt - st0, 0);
            end
            model_copy(vecs[v].src, vecs[v].dst, int'(vecs[v].len));
            check_mem($sformatf("mem_v%0d", v));
        end
        check("mem_0100", mem[16'h0100], 16'h0001);
        check("mem_0101", mem[16'h0101], 16'hFFFF);

        // ---------------- grant stalls ------------------------------------
        BG = 1'b0;
        start_cmd(16'h0800, 16'h0900, 16'd4);
        hits = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (BR && !d_readM && !d_writeM) hits++;
        end
        check("stall_wait_grant", hits, 5);
        BG = 1'b1;
        found = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (d_writeM && d_address == 16'h0901) begin
                found = 1;
                break;
            end
        end
        check("second_wr_seen", found, 1);
        BG = 1'b0;
        hits = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (BR && !d_readM && !d_writeM) hits++;
        end
        check("stall_word_boundary", hits, 3);
        check("second_word_written", mem[16'h0901], model[16'h0801]);
        BG = 1'b1;
        wait_done(1'b0, cycles);
        check_after_done();
        model_copy(16'h0800, 16'h0900, 4);
        check_mem("mem_stall");

        // ---------------- reset during RD2 of word 1 ----------------------
        dn0 = done_cnt;
        start_cmd(16'h0A00, 16'h0B00, 16'd3);
        hits = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (d_readM && d_address == 16'h0A01) hits++;
            if (hits == 2) break;
        end
        check("rd2_word1_reached", hits, 2);
        reset = 1'b1;
        #1;
        check("midreset_outputs", {BR, d_readM, d_writeM, busy, done}, 5'b0);
        check("midreset_address", d_address, 16'h0000);
        check("midreset_ready", cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("midreset_no_done", done_cnt - dn0, 0);
        check("midreset_idle", {busy, cmd_ready}, 2'b01);
        model_copy(16'h0A00, 16'h0B00, 1);
        check_mem("mem_midreset");

        check("never_rd_and_wr", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dma_controller.md
DMA_CONTROLLER -- requirements
Module: dma_controller

Interface
REQ-001 Parameter: WORD_SIZE, 16, width of data and address buses.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cmd_valid  input  1  transfer command present.
REQ-005 cmd_ready  output  1  high only in IDLE; command accepted on posedge with cmd_valid&cmd_ready.
REQ-006 cmd_src  input  16  source start word address, sampled at acceptance.
REQ-007 cmd_dst  input  16  destination start word address, sampled at acceptance.
REQ-008 cmd_len  input  16  word count, sampled at acceptance.
REQ-009 BR  output  1  bus request to CPU.
REQ-010 BG  input  1  bus grant from CPU.
REQ-011 d_readM  output  1  memory data-port read strobe.
REQ-012 d_writeM  output  1  memory data-port write strobe.
REQ-013 d_address  output  16  memory data-port word address.
REQ-014 d_data  inout  16  memory data bus; driven only in WR, else high-Z.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle completion pulse.

Function
REQ-017 States: IDLE, REQ, RD1, RD2, WR, DONE; outputs decoded from state/registers only, no input-to-output combinational path.
REQ-018 IDLE: on acceptance latch src, dst, len, clear index to 0; len==0 -> DONE, else -> REQ.
REQ-019 REQ: BR=1; BG sampled high -> RD1; else stay.
REQ-020 RD1: BR=1, d_readM=1, d_address=src+index.
REQ-021 RD2: BR=1, d_readM=1, same address; d_data captured into word buffer at end of cycle; -> WR.
REQ-022 WR: BR=1, d_writeM=1, d_address=dst+index, d_data=buffer; at edge index increments.
REQ-023 After WR: index+1==len -> DONE; else BG high -> RD1; BG low -> REQ (pause at word boundary, counters held).
REQ-024 BG deassertion during RD1/RD2/WR does not abort the current word; it completes before BR is re-evaluated.
REQ-025 DONE: done=1, BR=0, strobes low; -> IDLE next edge.
REQ-026 Address arithmetic modulo 2^16; src+index and dst+index wrap from 0xFFFF to 0x0000.
REQ-027 d_readM and d_writeM never high in the same cycle.
REQ-028 cmd_valid while busy ignored; no queuing.
REQ-029 With BG held high, done asserts 3*len+1 cycles after the acceptance edge (len>=1); len==0 asserts done the cycle after acceptance with BR never raised.
REQ-030 Overlapping src/dst ranges copy in ascending order with no hazard protection; result is defined by sequential word order.

Reset
REQ-031 reset high forces IDLE immediately, independent of clk.
REQ-032 Reset values: BR=0, d_readM=0, d_writeM=0, d_address=0, d_data high-Z, busy=0, done=0, cmd_ready=1 after release; latched src/dst/len/index/buffer=0.
REQ-033 reset mid-transfer abandons the transfer; words already written remain, no done pulse.

Verification
REQ-034 mem[0x0001]=0x0001, mem[0x0002]=0xFFFF; cmd src=0x0001 dst=0x0100 len=2, BG tied high -> mem[0x0100]=0x0001, mem[0x0101]=0xFFFF, done exactly 7 cycles after acceptance, single pulse.
REQ-035 cmd len=0 -> done next cycle, BR, d_readM, d_writeM never high, memory unchanged.
REQ-036 len=4, BG low for 5 cycles after BR, then high; BG dropped during second WR for 3 cycles -> BR held, second word written, stall in REQ, all 4 words correct.
REQ-037 src=0xFFFF len=2 -> reads from 0xFFFF then 0x0000; dst=0x01FF len=2 -> writes 0x01FF then 0x0200.
REQ-038 reset asserted during RD2 of word 1 of len=3 -> all outputs at reset values in same cycle, d_data high-Z, word 0 written, words 1-2 untouched, no done.
REQ-039 Second cmd_valid pulse while busy -> cmd_ready=0, ignored; first transfer result and timing unchanged.
